// File: rtl/age_matrix_multi_sel_if.sv
// Handshake/bus bundle between the issue-queue owner and age_matrix_multi_sel.
// Optional occupancy outputs exist only when AGE_MATRIX_OCC_EN is defined.
interface age_matrix_multi_sel_if #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ENQ_WIDTH = 2,
    parameter int unsigned DEQ_WIDTH = 2
);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [ENQ_WIDTH-1:0]       enq_valid;
    logic [ENQ_WIDTH*DEPTH-1:0] enq_idx_oh;
    logic [DEPTH-1:0]           entries_ready;
    logic [DEQ_WIDTH-1:0]       deq_fire;
    logic                       flush_valid;
    logic [DEPTH-1:0]           flush_mask;
    logic [DEQ_WIDTH-1:0]       sel_valid;
    logic [DEQ_WIDTH*DEPTH-1:0] sel_oh;
    logic [DEPTH-1:0]           entries_valid;
`ifdef AGE_MATRIX_OCC_EN
    logic [OCC_W-1:0]           occ_cnt;
    logic                       full;

    modport master (
        output enq_valid, enq_idx_oh, entries_ready, deq_fire, flush_valid, flush_mask,
        input  sel_valid, sel_oh, entries_valid, occ_cnt, full
    );
    modport slave (
        input  enq_valid, enq_idx_oh, entries_ready, deq_fire, flush_valid, flush_mask,
        output sel_valid, sel_oh, entries_valid, occ_cnt, full
    );
`else
    modport master (
        output enq_valid, enq_idx_oh, entries_ready, deq_fire, flush_valid, flush_mask,
        input  sel_valid, sel_oh, entries_valid
    );
    modport slave (
        input  enq_valid, enq_idx_oh, entries_ready, deq_fire, flush_valid, flush_mask,
        output sel_valid, sel_oh, entries_valid
    );
`endif
endinterface

// File: rtl/age_matrix_multi_sel.sv
// Age-matrix ordering for an issue queue: multi-lane enqueue, multi-port
// oldest-ready select, dequeue and masked flush.
// Optional macro AGE_MATRIX_OCC_EN adds registered occ_cnt and full outputs.
module age_matrix_multi_sel #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ENQ_WIDTH = 2,
    parameter int unsigned DEQ_WIDTH = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    age_matrix_multi_sel_if.slave  bus
);
    // age_q[i][j] = 1 means entry i is older than entry j
    logic [DEPTH-1:0][DEPTH-1:0]     age_q, age_d;
    logic [DEPTH-1:0]                valid_q, valid_d;

    logic [DEQ_WIDTH-1:0][DEPTH-1:0] sel;
    logic [DEQ_WIDTH-1:0]            sel_v;
    logic [DEPTH-1:0]                cand, blk;

    logic [ENQ_WIDTH-1:0][DEPTH-1:0] enq_e;
    logic [DEPTH-1:0]                freed, kill, surv, prior;
    logic [DEPTH-1:0][DEPTH-1:0]     col_new;

    // Port cascade: each port takes the oldest remaining ready entry
    always_comb begin
        cand  = valid_q & bus.entries_ready;
        sel   = '0;
        sel_v = '0;
        blk   = '0;
        for (int unsigned p = 0; p < DEQ_WIDTH; p++) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                blk[i] = 1'b0;
                for (int unsigned j = 0; j < DEPTH; j++) begin
                    blk[i] = blk[i] | (cand[j] & age_q[j][i]);
                end
                sel[p][i] = cand[i] & ~blk[i];
            end
            sel_v[p] = |sel[p];
            cand     = cand & ~sel[p];
        end
    end

    assign bus.sel_oh        = sel;
    assign bus.sel_valid     = sel_v;
    assign bus.entries_valid = valid_q;

    // Next-state: frees, flush kills, enqueue columns, cell precedence
    always_comb begin
        freed = '0;
        for (int unsigned p = 0; p < DEQ_WIDTH; p++) begin
            if (bus.deq_fire[p]) freed = freed | sel[p];
        end
        kill = freed | (bus.flush_valid ? bus.flush_mask : '0);
        surv = valid_q & ~kill;

        // A new entry's column holds every survivor plus entries enqueued by lower lanes
        enq_e   = '0;
        prior   = '0;
        col_new = '0;
        for (int unsigned k = 0; k < ENQ_WIDTH; k++) begin
            if (bus.enq_valid[k] && !bus.flush_valid) enq_e[k] = bus.enq_idx_oh[k*DEPTH +: DEPTH];
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (enq_e[k][j]) col_new[j] = surv | prior;
            end
            prior = prior | enq_e[k];
        end

        valid_d = surv | prior;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (i == j)                   age_d[i][j] = 1'b0;
                else if (prior[i] | prior[j]) age_d[i][j] = prior[j] & col_new[j][i];
                else if (kill[i] | kill[j])   age_d[i][j] = 1'b0;
                else                          age_d[i][j] = age_q[i][j];
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            age_q   <= '0;
            valid_q <= '0;
        end else begin
            age_q   <= age_d;
            valid_q <= valid_d;
        end
    end

`ifdef AGE_MATRIX_OCC_EN
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             full_q;

    // Population count of the next occupancy vector
    always_comb begin
        occ_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + OCC_W'(valid_d[i]);
        end
    end

    // Occupancy registers track valid_q one-for-one
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            occ_q  <= '0;
            full_q <= 1'b0;
        end else begin
            occ_q  <= occ_d;
            full_q <= (occ_d == OCC_W'(DEPTH));
        end
    end

    assign bus.occ_cnt = occ_q;
    assign bus.full    = full_q;
`endif
endmodule

// File: tb/tb_age_matrix_multi_sel.sv
// Directed, table-driven bench for age_matrix_multi_sel (DEPTH=16, 2 lanes, 2 ports).
module tb_age_matrix_multi_sel;
    localparam int unsigned DEPTH = 16;
    localparam logic [15:0] ALL = 16'hFFFF;
    localparam logic [15:0] NON = 16'h0000;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    age_matrix_multi_sel_if #(.DEPTH(16), .ENQ_WIDTH(2), .DEQ_WIDTH(2)) bus ();

    age_matrix_multi_sel #(.DEPTH(16), .ENQ_WIDTH(2), .DEQ_WIDTH(2)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct {
        logic [1:0]  enq_v;
        logic [15:0] e0;
        logic [15:0] e1;
        logic [15:0] rdy;
        logic [1:0]  fire;
        logic        fv;
        logic [15:0] fm;
        logic [1:0]  exp_sv;
        logic [15:0] exp_s0;
        logic [15:0] exp_s1;
        logic [15:0] exp_valid;
    } vec_t;

    vec_t vq[$];
    int checks   = 0;
    int failures = 0;

    function automatic logic [15:0] oh(input int i);
        logic [15:0] one;
        one = 16'h0001;
        return one << i;
    endfunction

    task automatic add(input logic [1:0] enq_v, input logic [15:0] e0, input logic [15:0] e1,
                       input logic [15:0] rdy, input logic [1:0] fire, input logic fv,
                       input logic [15:0] fm, input logic [1:0] esv, input logic [15:0] es0,
                       input logic [15:0] es1, input logic [15:0] ev);
        vec_t v;
        v.enq_v = enq_v; v.e0 = e0; v.e1 = e1; v.rdy = rdy; v.fire = fire; v.fv = fv;
        v.fm = fm; v.exp_sv = esv; v.exp_s0 = es0; v.exp_s1 = es1; v.exp_valid = ev;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] enq_v, input logic [15:0] e0, input logic [15:0] e1,
                         input logic [15:0] rdy, input logic [1:0] fire, input logic fv,
                         input logic [15:0] fm);
        bus.enq_valid     = enq_v;
        bus.enq_idx_oh    = {e1, e0};
        bus.entries_ready = rdy;
        bus.deq_fire      = fire;
        bus.flush_valid   = fv;
        bus.flush_mask    = fm;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(2'b00, NON, NON, ALL, 2'b00, 1'b0, NON);
        @(posedge clock); #1;
        chk("reset_valid", 32'(bus.entries_valid), 32'h0);
        chk("reset_sel_valid", 32'(bus.sel_valid), 32'h0);
        chk("reset_sel_oh", bus.sel_oh, 32'h0);
`ifdef AGE_MATRIX_OCC_EN
        chk("reset_occ", 32'(bus.occ_cnt), 32'd0);
`endif
        reset_n = 1'b1;

        //   enq   e0      e1      rdy          fire  fv  fm        esv   es0     es1     valid_after
        add(2'b01, oh(3),  NON,    ALL,         2'b00, 0, NON,      2'b00, NON,   NON,    oh(3));
        add(2'b01, oh(7),  NON,    ALL,         2'b00, 0, NON,      2'b01, oh(3), NON,    oh(3)|oh(7));
        add(2'b01, oh(1),  NON,    ALL,         2'b00, 0, NON,      2'b11, oh(3), oh(7),  oh(3)|oh(7)|oh(1));
        add(2'b00, NON,    NON,    oh(7)|oh(1), 2'b00, 0, NON,      2'b11, oh(7), oh(1),  oh(3)|oh(7)|oh(1));
        add(2'b00, NON,    NON,    oh(7)|oh(1), 2'b11, 0, NON,      2'b11, oh(7), oh(1),  oh(3));
        add(2'b11, oh(5),  oh(2),  NON,         2'b00, 0, NON,      2'b00, NON,   NON,    oh(3)|oh(5)|oh(2));
        add(2'b00, NON,    NON,    oh(5)|oh(2), 2'b00, 0, NON,      2'b11, oh(5), oh(2),  oh(3)|oh(5)|oh(2));
        add(2'b00, NON,    NON,    ALL,         2'b01, 0, NON,      2'b11, oh(3), oh(5),  oh(5)|oh(2));
        add(2'b11, oh(4),  oh(9),  NON,         2'b00, 0, NON,      2'b00, NON,   NON,    oh(5)|oh(2)|oh(4)|oh(9));
        add(2'b00, NON,    NON,    ALL,         2'b11, 0, NON,      2'b11, oh(5), oh(2),  oh(4)|oh(9));
        add(2'b01, oh(4),  NON,    ALL,         2'b01, 0, NON,      2'b11, oh(4), oh(9),  oh(4)|oh(9));
        add(2'b00, NON,    NON,    ALL,         2'b00, 0, NON,      2'b11, oh(9), oh(4),  oh(4)|oh(9));
        add(2'b01, oh(5),  NON,    ALL,         2'b00, 0, NON,      2'b11, oh(9), oh(4),  oh(9)|oh(4)|oh(5));
        add(2'b01, oh(12), NON,    NON,         2'b00, 1, 16'h00F0, 2'b00, NON,   NON,    oh(9));
        add(2'b00, NON,    NON,    ALL,         2'b00, 0, NON,      2'b01, oh(9), NON,    oh(9));
        add(2'b11, oh(1),  oh(0),  NON,         2'b00, 0, NON,      2'b00, NON,   NON,    oh(9)|oh(1)|oh(0));
        add(2'b00, NON,    NON,    ALL,         2'b10, 1, oh(9),    2'b11, oh(9), oh(1),  oh(0));
        add(2'b00, NON,    NON,    ALL,         2'b11, 0, NON,      2'b01, oh(0), NON,    NON);
        add(2'b11, oh(15), oh(14), ALL,         2'b11, 0, NON,      2'b00, NON,   NON,    oh(15)|oh(14));
        add(2'b00, NON,    NON,    ALL,         2'b00, 0, NON,      2'b11, oh(15), oh(14), oh(15)|oh(14));

        foreach (vq[n]) begin
            @(negedge clock);
            drive(vq[n].enq_v, vq[n].e0, vq[n].e1, vq[n].rdy, vq[n].fire, vq[n].fv, vq[n].fm);
            #1;
            chk($sformatf("v%0d_sel_valid", n), 32'(bus.sel_valid), 32'(vq[n].exp_sv));
            chk($sformatf("v%0d_sel0", n), 32'(bus.sel_oh[15:0]), 32'(vq[n].exp_s0));
            chk($sformatf("v%0d_sel1", n), 32'(bus.sel_oh[31:16]), 32'(vq[n].exp_s1));
            @(posedge clock); #1;
            chk($sformatf("v%0d_valid", n), 32'(bus.entries_valid), 32'(vq[n].exp_valid));
        end

        // Fill to six entries, then reset mid-operation with a competing enqueue
        @(negedge clock);
        drive(2'b11, oh(0), oh(1), NON, 2'b00, 1'b0, NON);
        @(negedge clock);
        drive(2'b11, oh(2), oh(3), NON, 2'b00, 1'b0, NON);
        @(negedge clock);
        drive(2'b00, NON, NON, ALL, 2'b00, 1'b0, NON);
        #1;
        chk("six_valid", 32'(bus.entries_valid), 32'h0000C00F);
        chk("six_sel0", 32'(bus.sel_oh[15:0]), 32'(oh(15)));
        chk("six_sel1", 32'(bus.sel_oh[31:16]), 32'(oh(14)));
`ifdef AGE_MATRIX_OCC_EN
        chk("six_occ", 32'(bus.occ_cnt), 32'd6);
        chk("six_full", 32'(bus.full), 32'd0);
`endif
        @(negedge clock);
        reset_n = 1'b0;
        drive(2'b01, oh(5), NON, ALL, 2'b11, 1'b0, NON);
        @(posedge clock); #1;
        chk("midrst_valid", 32'(bus.entries_valid), 32'h0);
        chk("midrst_sel_valid", 32'(bus.sel_valid), 32'h0);
        chk("midrst_sel_oh", bus.sel_oh, 32'h0);
`ifdef AGE_MATRIX_OCC_EN
        chk("midrst_occ", 32'(bus.occ_cnt), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/age_matrix_multi_sel.md
Name: age_matrix_multi_sel

Overview:
- Parametrised successor to the issue-queue age-ordering logic.
- Tracks the relative age of up to DEPTH issue-queue entries in an internal age matrix and valid vector.
- Accepts up to ENQ_WIDTH enqueues per cycle, with lane order defining relative age.
- Selects the oldest ready entries for up to DEQ_WIDTH issue ports per cycle and supports masked flush.
- Sits between issue-queue entry storage and the issue ports.

Parameters:
DEPTH, 16, number of issue-queue entries (>=2)
ENQ_WIDTH, 2, enqueue lanes per cycle (>=1)
DEQ_WIDTH, 2, select/issue ports per cycle (>=1, <=DEPTH)

Ports:
clock  in  1  single clock; all state updates on rising edge
reset_n  in  1  synchronous, active-low reset, sampled on rising edge of clock
enq_valid  in  ENQ_WIDTH  lane k enqueues this cycle
enq_idx_oh  in  ENQ_WIDTH*DEPTH  lane k target entry, one-hot, slice [k*DEPTH +: DEPTH]
entries_ready  in  DEPTH  entry operands ready (from queue wakeup logic)
deq_fire  in  DEQ_WIDTH  port p accepted its selection this cycle
flush_valid  in  1  flush request
flush_mask  in  DEPTH  entries to kill when flush_valid
sel_valid  out  DEQ_WIDTH  port p has a selection (combinational)
sel_oh  out  DEQ_WIDTH*DEPTH  port p selected entry, one-hot, slice [p*DEPTH +: DEPTH] (combinational)
entries_valid  out  DEPTH  registered occupancy vector

Behaviour:
- State: age[i][j] (DEPTH x DEPTH; 1 = entry i older than entry j; diagonal always 0) and valid[DEPTH].
- Reset (reset_n=0 at posedge): all age and valid bits 0. Hence entries_valid=0, sel_valid=0, sel_oh=0. Reset overrides all other inputs that cycle.
- Selection (combinational from registered state plus entries_ready; zero latency):
  - cand0 = valid & entries_ready.
  - sel_oh[p][i] = cand_p[i] & ~OR_j(cand_p[j] & age[j][i]).
  - sel_valid[p] = |sel_oh[p].
  - cand_{p+1} = cand_p & ~sel_oh[p].
  - The port-p pick is the oldest ready entry not taken by ports 0..p-1.
  - Non-ready older entries do NOT block younger ready entries.
  - Matrix consistency guarantees at most one bit per sel_oh[p].
- Dequeue: deq_fire[p]=1 with sel_valid[p]=1 frees the sel_oh[p] entry at the next edge (valid<=0, row and column <=0). deq_fire[p] with sel_valid[p]=0 is ignored.
- Survivors: surv = valid & ~freed & ~(flush_valid ? flush_mask : 0), where freed = OR of fired sel_oh.
- Enqueue, lane k to entry e (ignored entirely when flush_valid=1):
  - valid[e]<=1; age[e][*]<=0 except as below.
  - age[j][e]<=1 for every j in surv.
  - age[e_m][e]<=1 for every enqueuing lane m<k (lower lane is older).
  - age[e][e_m]<=0 for m<k.
- Cell update precedence:
  1. Fresh enqueue of row or column entry sets the computed value.
  2. Otherwise, if the row or column entry is freed or flushed, the cell <=0.
  3. Otherwise the cell holds.
- Enqueue into an entry being dequeued the same cycle is legal; the new entry is younger than all survivors.
- Enqueue into a valid, non-freed entry, or two lanes targeting the same entry, is illegal; the result is unspecified.
- Non-one-hot enq_idx_oh with enq_valid=1 is illegal.
- Flush: valid and row/column cleared for masked entries. Enqueues that cycle are dropped. deq_fire that cycle still frees its entries.
- Full or empty: no internal stall. The queue owner guarantees free targets.
- Empty matrix: sel_valid=0.
- Ages are order-only, with no counters, so there is no wrap-around concern.

Optional Feature:
- AGE_MATRIX_OCC_EN defined:
  - Adds output occ_cnt, width $clog2(DEPTH+1), registered, equal to popcount(valid). Resets to 0.
  - Adds output full = (occ_cnt==DEPTH), registered.
- Undefined: neither port nor counter exists; all other behaviour identical.

Test Plan:
- Reset, then DEPTH=16: enqueue entries 3,7,1 on successive cycles, all ready -> sel_oh[0]=entry 3, sel_oh[1]=entry 7, both sel_valid=1.
- Same cycle, lane0->entry 5, lane1->entry 2 -> age[5][2]=1; with both ready, port0 picks 5, port1 picks 2.
- Entries 3(oldest),7,1 valid; only 7 and 1 ready -> port0=7, port1=1 (non-ready 3 does not block). Fire both -> entries_valid={3} only.
- Entry 4 is oldest and fired on port0 while lane0 enqueues into 4 the same cycle -> next cycle entry 4 is valid and youngest; age[*][4]=1 for all other valid entries.
- Flush_mask=0x00F0 with entries 4,5,9 valid plus a simultaneous enqueue to 12 -> only 9 valid next cycle, entry 12 not valid.
- reset_n low mid-operation with 6 entries valid -> next edge entries_valid=0, sel_valid=0, occ_cnt=0 (AGE_MATRIX_OCC_EN).
